// File: rtl/picoblaze_sample_port.sv
// picoblaze_sample_port
//   I/O-port responder for a PicoBlaze CPU. External byte samples are
//   captured into a small FIFO. Each accepted sample can raise an interrupt.
//   The CPU pops samples and reads status with INPUT instructions, and it
//   controls the block with OUTPUT instructions.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   sample_strobe/data   one-cycle push of an external byte
//   port_id              CPU port address (shared by reads and writes)
//   read_strobe          CPU INPUT qualifier (DATA_PORT read pops the FIFO)
//   write_strobe         CPU OUTPUT qualifier
//   out_port             CPU write data (CTRL_PORT: [0] flush, [1] clear
//                        overflow, [2] interrupt enable)
//   in_port              registered read data, one cycle after port_id
//   interrupt            interrupt request, cleared by interrupt_ack
//   interrupt_ack        CPU acknowledge
module picoblaze_sample_port #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter logic [7:0]  DATA_PORT   = 8'h00,
  parameter logic [7:0]  STATUS_PORT = 8'h01,
  parameter logic [7:0]  CTRL_PORT   = 8'h02
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sample_strobe,
  input  logic [7:0] sample_data,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(FIFO_DEPTH);

  logic [7:0]        mem_r [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              overflow_r;
  logic              int_en_r;

  logic              empty_s;
  logic              full_s;
  logic              pop_s;
  logic              ctrl_wr_s;
  logic              flush_s;
  logic              clr_ovf_s;
  logic              push_acc_s;
  logic              ovf_evt_s;
  logic [4:0]        count5_s;
  logic [7:0]        rd_data_s;
  logic              irq_next_s;
  logic              unused_ctrl_bits_s;

  // Control-write bits 7..3 carry no meaning.
  assign unused_ctrl_bits_s = ^out_port[7:3];

  // FIFO flags and the qualified bus events for this cycle.
  always_comb begin
    empty_s    = (count_r == '0);
    full_s     = (count_r == DEPTH_C);
    count5_s   = 5'(count_r);
    pop_s      = read_strobe && (port_id == DATA_PORT) && !empty_s;
    ctrl_wr_s  = write_strobe && (port_id == CTRL_PORT);
    flush_s    = ctrl_wr_s && out_port[0];
    clr_ovf_s  = ctrl_wr_s && out_port[1];
    // A full FIFO still accepts a sample when a pop frees a slot in the
    // same cycle; a flush discards any same-cycle sample.
    push_acc_s = sample_strobe && !flush_s && (!full_s || pop_s);
    ovf_evt_s  = sample_strobe && !flush_s && full_s && !pop_s;
    irq_next_s = (interrupt && !interrupt_ack) || (push_acc_s && int_en_r);
  end

  // Read-data mux, decoded from the current port_id and pre-update state.
  always_comb begin
    rd_data_s = 8'h00;
    if (port_id == DATA_PORT) begin
      if (!empty_s) begin
        rd_data_s = mem_r[rd_ptr_r];
      end else begin
        rd_data_s = 8'h00;
      end
    end else if (port_id == STATUS_PORT) begin
      rd_data_s = {count5_s, overflow_r, full_s, empty_s};
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // Sample storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_acc_s) begin
      mem_r[wr_ptr_r] <= sample_data;
    end
  end

  // Pointers, occupancy, sticky overflow, interrupt and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      int_en_r   <= 1'b0;
      interrupt  <= 1'b0;
      in_port    <= 8'h00;
    end else begin
      in_port   <= rd_data_s;
      interrupt <= irq_next_s;

      if (flush_s) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        count_r  <= '0;
      end else begin
        if (push_acc_s) begin
          wr_ptr_r <= wr_ptr_r + 1'b1;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + 1'b1;
        end
        case ({push_acc_s, pop_s})
          2'b10:   count_r <= count_r + 1'b1;
          2'b01:   count_r <= count_r - 1'b1;
          default: count_r <= count_r;
        endcase
      end

      // An overflow in the same cycle as a clear request keeps the flag set.
      if (ovf_evt_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf_s) begin
        overflow_r <= 1'b0;
      end

      if (ctrl_wr_s) begin
        int_en_r <= out_port[2];
      end
    end
  end

endmodule
